// File: rtl/vga_bus_arbiter_if.sv
// Handshake bundle between the drawing requesters and the VGA pixel-bus arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface vga_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done_in;
  logic [NUM_REQ-1:0] enable_out;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_flag;

  modport master (
    output req, done_in,
    input  enable_out, grant_id, busy, timeout_flag
  );

  modport slave (
    input  req, done_in,
    output enable_out, grant_id, busy, timeout_flag
  );
endinterface

// File: rtl/vga_bus_arbiter.sv
// Round-robin arbiter for the shared VGA pixel bus.
// Owner gets a one-cycle enable pulse, keeps the bus until its done_in pulse,
// then the bus spends one release (turnaround) cycle and one idle cycle before
// the next grant. Optional watchdog: define ARB_TIMEOUT_EN to force release of
// an owner that stays in S_WAIT for TIMEOUT_CYCLES cycles.
module vga_bus_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter logic [16:0] TIMEOUT_CYCLES = 17'd70000
) (
  input  logic               clk,
  input  logic               reset,
  vga_bus_arbiter_if.slave   bus
);

  // grant_id is a fixed 2-bit field, so up to four requesters are addressable
  localparam int GW = 2;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RELEASE} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] enable_out;
  logic [GW-1:0]      grant_id;
  logic [GW-1:0]      last_grant;
  logic               busy;
  logic               timeout_flag;

  // First set request bit strictly after 'last', wrapping; the nearest
  // candidate is visited last so it overwrites any farther one.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] w;
    int            idx;
    w = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (r[idx]) w = GW'(idx);
    end
    return w;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [16:0] tmo_cnt;
`else
  // Watchdog compiled out: the limit has no consumer
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Arbitration FSM; every output is a register updated with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      enable_out   <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      last_grant   <= GW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      enable_out   <= '0;
      timeout_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            grant_id <= rr_pick(bus.req, last_grant);
            busy     <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          enable_out <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // Only the owner's done counts; a done on the final cycle wins over the timeout
          if (bus.done_in[grant_id]) begin
            state <= S_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt >= TIMEOUT_CYCLES - 17'd1) begin
            timeout_flag <= 1'b1;
            state        <= S_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 17'd1;
          end
`endif
        end
        S_RELEASE: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.enable_out   = enable_out;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = busy;
  assign bus.timeout_flag = timeout_flag;

endmodule

// File: doc/vga_bus_arbiter.md
VGA_BUS_ARBITER -- requirements
Module: vga_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of drawing requesters sharing the VGA pixel bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 17'd70000, maximum cycles in S_WAIT before forced release.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester level request for bus ownership.
REQ-006 done_in  input  NUM_REQ  per-requester one-cycle completion pulse.
REQ-007 enable_out  output  NUM_REQ  one-hot one-cycle start pulse to the granted requester.
REQ-008 grant_id  output  2  index of the current or last owner.
REQ-009 busy  output  1  high while the bus is owned or turning around.
REQ-010 timeout_flag  output  1  one-cycle pulse on forced release.

Function
REQ-011 States: S_IDLE, S_GRANT, S_WAIT, S_RELEASE; all outputs registered.
REQ-012 S_IDLE: req == 0 -> stay; otherwise select winner, load grant_id, go to S_GRANT.
REQ-013 Round-robin winner: first set req bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
REQ-014 S_GRANT lasts exactly one cycle: enable_out[grant_id] = 1, all other bits 0; then go to S_WAIT.
REQ-015 Latency: req sampled high at edge k -> enable_out high during cycle after edge k+1.
REQ-016 S_WAIT: done_in[grant_id] high -> go to S_RELEASE; done_in of non-granted requesters is ignored.
REQ-017 done_in is not sampled in S_IDLE, S_GRANT or S_RELEASE.
REQ-018 S_RELEASE lasts exactly one cycle as a tri-state bus turnaround; last_grant <= grant_id; then go to S_IDLE.
REQ-019 Consecutive grants are separated by at least one S_RELEASE and one S_IDLE cycle.
REQ-020 busy = 1 in S_GRANT, S_WAIT and S_RELEASE; busy = 0 in S_IDLE.
REQ-021 A req deasserted after grant does not abort ownership; the arbiter waits for done_in.
REQ-022 A requester holding req high is re-granted only after all other pending requesters are served.
REQ-023 Single requester: repeated grants to the same index, one per done cycle.
REQ-024 Simultaneous done_in and timeout expiry in the same cycle: treat as normal done; timeout_flag stays 0.

Reset
REQ-025 reset high at an edge: state = S_IDLE, enable_out = 0, grant_id = 0, busy = 0, timeout_flag = 0, last_grant = NUM_REQ-1 (so req[0] wins first), timeout counter = 0.
REQ-026 reset overrides all other inputs, including mid-S_WAIT; the requester is not notified.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: a 17-bit counter clears on S_GRANT and increments each S_WAIT cycle. On reaching TIMEOUT_CYCLES without done it forces S_RELEASE, pulses timeout_flag for one cycle, and rotates last_grant.
REQ-028 Macro ARB_TIMEOUT_EN undefined: there is no counter, S_WAIT waits indefinitely, and timeout_flag is tied to 0.

Verification
REQ-029 Reset, then req=4'b0001 -> enable_out=4'b0001 for exactly one cycle, 2 cycles after req; grant_id=0; busy=1 until 1 cycle after done_in[0].
REQ-030 req=4'b1111 held, each owner pulses done_in 10 cycles after its enable -> grant order 0,1,2,3,0; each handoff shows 1 release + 1 idle cycle.
REQ-031 Owner 2 in S_WAIT, done_in=4'b0001 pulsed -> ignored; state stays S_WAIT; busy stays 1.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, owner never finishes -> timeout_flag pulses once, 100 cycles into S_WAIT; next grant goes to the next pending index.
REQ-033 reset asserted 50 cycles into S_WAIT -> all outputs 0 next cycle; next req=4'b1000 grants index 3.
REQ-034 Single req=4'b0100 held, done pulses -> enable_out[2] re-pulses every (wait+4) cycles; grant_id stays 2.
